// File: rtl/seq_divider32.sv
// ============================================================================
// seq_divider32 : iterative unsigned restoring divider, one quotient bit/clock
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_divider32 #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step; the extra top bit of trial holds the shifted-out carry.
  always_comb begin
    trial  = {r_q, q_q[WIDTH-1]};
    fits   = (trial >= {1'b0, d_q});
    r_next = fits ? (trial[WIDTH-1:0] - d_q) : trial[WIDTH-1:0];
    q_next = {q_q[WIDTH-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (B != '0) begin
            q_d     = A;
            d_d     = B;
            r_d     = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            // Divide by zero completes immediately without entering RUN.
            quo_d  = '1;
            rem_d  = A;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        q_d   = q_next;
        r_d   = r_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = q_next;
          rem_d   = r_next;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;

endmodule

`default_nettype wire
